// File: rtl/decade_down_counter_pkg.sv
// Shared constants and helpers for the BCD down-counter.
//   BCD_MAX_DIGIT : largest legal BCD digit (9)
//   BCD_ZERO      : BCD zero digit
//   is_bcd_digit  : returns 1 when a 4-bit nibble is a legal BCD digit
package decade_down_counter_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] BCD_ZERO      = 4'd0;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter borrow chain (purely combinational).
// Ports:
//   digit      : current value of this digit
//   borrow_in  : decrement request from the lower digit (or the enable for digit 0)
//   load       : replace the digit with load_digit (overrides borrow_in)
//   load_digit : value used when load is high
//   next_digit : value to register on the next edge
//   borrow_out : this digit wraps 0 -> 9, so the next digit must decrement
module bcd_down_digit
    import decade_down_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        if (load) begin
            next_digit = load_digit;
        end else if (borrow_in) begin
            next_digit = (digit == BCD_ZERO) ? BCD_MAX_DIGIT : (digit - 4'd1);
        end
    end

    assign borrow_out = (digit == BCD_ZERO) && borrow_in;

endmodule

// File: rtl/decade_down_counter.sv
// Loadable cascaded BCD down-counter with terminal-count flag and optional
// auto-reload from the last accepted load value.
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   en          : count enable, one decrement per clock
//   load        : load strobe (wins over en); samples load_val
//   load_val    : BCD value to load, digit 0 in bits [3:0]
//   auto_reload : 0 = stop at zero, 1 = reload from last loaded value
//   count       : current BCD value (registered)
//   zero        : count == 0 (combinational)
//   tc          : one-cycle pulse on the edge count reaches zero
//   busy        : counter armed
//   load_err    : one-cycle pulse after a load with a non-BCD digit
module decade_down_counter
    import decade_down_counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  tc,
    output logic                  busy,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] COUNT_ONE = W'(1);

    logic [W-1:0]    count_q;
    logic [W-1:0]    reload_q;
    logic            busy_q;
    logic            tc_q;
    logic            load_err_q;

    logic            load_valid;
    logic            count_nz;
    logic            dec;
    logic            reload_now;
    logic            digit_load;
    logic [W-1:0]    digit_load_val;
    logic [W-1:0]    next_count;
    logic [DIGITS:0] borrow;

    always_comb begin
        load_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(load_val[4*i +: 4])) begin
                load_valid = 1'b0;
            end
        end
    end

    assign count_nz   = (count_q != '0);
    assign dec        = !load && en && busy_q && count_nz;
    // An armed auto-reload counter sitting at zero spends one enabled
    // cycle there, then reloads; this gives an N+1 cycle period.
    assign reload_now = !load && en && busy_q && !count_nz && auto_reload;

    // Loads and reloads share the digits' parallel-load path.
    assign digit_load     = (load && load_valid) || reload_now;
    assign digit_load_val = load ? load_val : reload_q;
    assign borrow[0]      = dec;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .digit      (count_q[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .load       (digit_load),
            .load_digit (digit_load_val[4*g +: 4]),
            .next_digit (next_count[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            reload_q   <= '0;
            busy_q     <= 1'b0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
            count_q    <= next_count;
            if (load) begin
                if (load_valid) begin
                    reload_q <= load_val;
                    busy_q   <= (load_val != '0);
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (dec && (count_q == COUNT_ONE)) begin
                tc_q <= 1'b1;
                if (!auto_reload) begin
                    busy_q <= 1'b0;
                end
            end else if (busy_q && !count_nz && !auto_reload) begin
                // auto_reload dropped while parked at zero: disarm.
                busy_q <= 1'b0;
            end
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign tc       = tc_q;
    assign busy     = busy_q;
    assign load_err = load_err_q;

endmodule
